if_stage_pipe: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core. It holds the PC and an on-chip word-addressed instruction memory with a loader write port. It drives the IF/ID pipeline register toward decode. Unlike the single-cycle fetch, it supports stall, branch/jump redirect with flush, out-of-range and misalignment detection, and a fetch counter.

---
 rtl/if_stage_pipe.sv | 109 ++++++++++
 tb/tb_if_stage_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_pipe.sv
// Pipelined instruction-fetch stage: PC, loadable instruction memory and
// IF/ID register with stall, redirect/flush and sticky error flags.
module if_stage_pipe #(
  parameter int          IM_DEPTH = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000,
  localparam int         AW       = $clog2(IM_DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          im_we,
  input  logic [AW-1:0] im_waddr,
  input  logic [31:0]   im_wdata,
  output logic [31:0]   pc,
  output logic [31:0]   ifid_pc,
  output logic [31:0]   ifid_pc4,
  output logic [31:0]   ifid_ins,
  output logic          ifid_valid,
  output logic          range_err,
  output logic          align_err,
  output logic [31:0]   fetch_cnt
);

  logic [31:0] mem_q [IM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        range_err_q, range_err_d;
  logic        align_err_q, align_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic          oor;
  logic [AW-1:0] ridx;
  logic [31:0]   fw;
  logic [31:0]   pc_inc;

  // Loader port is deliberately not gated by reset.
  always_ff @(posedge CLK) begin
    if (im_we) mem_q[im_waddr] <= im_wdata;
  end

  assign oor    = |(pc_q >> (AW + 2));
  assign ridx   = pc_q[AW+1:2];
  assign fw     = oor ? NOP_INS : mem_q[ridx];
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_valid_d = ifid_valid_q;
    range_err_d  = range_err_q;
    align_err_d  = align_err_q;
    fetch_cnt_d  = fetch_cnt_q;
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_ins_d   = NOP_INS;
      ifid_valid_d = 1'b0;
      align_err_d  = align_err_q | (|redirect_pc[1:0]);
    end else if (!stall) begin
      pc_d         = pc_inc;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_inc;
      ifid_ins_d   = fw;
      ifid_valid_d = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + 32'd1;
      range_err_d  = range_err_q | oor;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_ins_q   <= NOP_INS;
      ifid_valid_q <= 1'b0;
      range_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
      fetch_cnt_q  <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_valid_q <= ifid_valid_d;
      range_err_q  <= range_err_d;
      align_err_q  <= align_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_ins   = ifid_ins_q;
  assign ifid_valid = ifid_valid_q;
  assign range_err  = range_err_q;
  assign align_err  = align_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: sequential fetch, stall, redirect,
// range/alignment flags, loader collision and asynchronous reset.
module tb_if_stage_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        im_we = 1'b0;
  logic [7:0]  im_waddr = 8'd0;
  logic [31:0] im_wdata = 32'd0;
  logic [31:0] pc, ifid_pc, ifid_pc4, ifid_ins, fetch_cnt;
  logic        ifid_valid, range_err, align_err;

  int n_chk = 0;
  int n_pass = 0;

  if_stage_pipe #(
    .IM_DEPTH(256),
    .RESET_PC(32'h0),
    .NOP_INS(NOP)
  ) dut (
    .CLK(CLK), .RST(RST), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .pc(pc), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_ins(ifid_ins), .ifid_valid(ifid_valid),
    .range_err(range_err), .align_err(align_err),
    .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] w [5];
    logic [7:0]  a [5];
    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hAA};
    a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd16};
    for (int i = 0; i < 5; i++) begin
      im_we = 1'b1; im_waddr = a[i]; im_wdata = w[i];
      step();
    end
    im_we = 1'b0;
    n_chk++;
    if (pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", pc, 32'h0);
    else n_pass++;
    n_chk++;
    if (ifid_ins !== NOP || ifid_valid !== 1'b0)
      $display("FAIL rst_ifid got %h/%b exp %h/0", ifid_ins, ifid_valid, NOP);
    else n_pass++;
    n_chk++;
    if (fetch_cnt !== 32'h0 || range_err !== 1'b0 || align_err !== 1'b0 ||
        ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0)
      $display("FAIL rst_misc got cnt=%h r=%b a=%b p=%h p4=%h exp zeros",
               fetch_cnt, range_err, align_err, ifid_pc, ifid_pc4);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] ei [4];
    ei = '{32'h11, 32'h22, 32'h33, 32'h44};
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (ifid_ins !== ei[i] || ifid_pc !== 32'(4 * i) ||
          ifid_pc4 !== 32'(4 * i + 4) || ifid_valid !== 1'b1)
        $display("FAIL seq_%0d got ins=%h pc=%h pc4=%h v=%b exp ins=%h pc=%h pc4=%h v=1",
                 i, ifid_ins, ifid_pc, ifid_pc4, ifid_valid,
                 ei[i], 32'(4 * i), 32'(4 * i + 4));
      else n_pass++;
    end
    n_chk++;
    if (fetch_cnt !== 32'd4 || pc !== 32'h10)
      $display("FAIL seq_cnt got cnt=%0d pc=%h exp cnt=4 pc=10", fetch_cnt, pc);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (pc !== 32'h8 || ifid_ins !== 32'h22 || fetch_cnt !== 32'd2)
        $display("FAIL stall_%0d got pc=%h ins=%h cnt=%0d exp pc=8 ins=22 cnt=2",
                 i, pc, ifid_ins, fetch_cnt);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_chk++;
    if (ifid_ins !== 32'h33 || fetch_cnt !== 32'd3 || pc !== 32'hC)
      $display("FAIL stall_rel got ins=%h cnt=%0d pc=%h exp ins=33 cnt=3 pc=c",
               ifid_ins, fetch_cnt, pc);
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0; stall = 1'b0;
    n_chk++;
    if (pc !== 32'h40 || ifid_valid !== 1'b0 || ifid_ins !== NOP ||
        align_err !== 1'b1 || ifid_pc !== 32'h8 || fetch_cnt !== 32'd3)
      $display("FAIL redir got pc=%h v=%b ins=%h al=%b ipc=%h cnt=%0d exp pc=40 v=0 ins=%h al=1 ipc=8 cnt=3",
               pc, ifid_valid, ifid_ins, align_err, ifid_pc, fetch_cnt, NOP);
    else n_pass++;
    step();
    n_chk++;
    if (ifid_ins !== 32'hAA || ifid_pc !== 32'h40 || ifid_valid !== 1'b1 ||
        fetch_cnt !== 32'd4)
      $display("FAIL redir_tgt got ins=%h ipc=%h v=%b cnt=%0d exp ins=aa ipc=40 v=1 cnt=4",
               ifid_ins, ifid_pc, ifid_valid, fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    n_chk++;
    if (range_err !== 1'b0) $display("FAIL range_pre got %b exp 0", range_err);
    else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    step();
    n_chk++;
    if (ifid_ins !== NOP || ifid_valid !== 1'b1 || range_err !== 1'b1 ||
        ifid_pc !== 32'h400 || fetch_cnt !== 32'd5)
      $display("FAIL range got ins=%h v=%b r=%b ipc=%h cnt=%0d exp ins=%h v=1 r=1 ipc=400 cnt=5",
               ifid_ins, ifid_valid, range_err, ifid_pc, fetch_cnt, NOP);
    else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    n_chk++;
    if (range_err !== 1'b1 || align_err !== 1'b1 || ifid_ins !== 32'h11)
      $display("FAIL sticky got r=%b a=%b ins=%h exp r=1 a=1 ins=11",
               range_err, align_err, ifid_ins);
    else n_pass++;
  endtask

  task automatic test_collision();
    redirect = 1'b1; redirect_pc = 32'h8;
    step();
    redirect = 1'b0;
    im_we = 1'b1; im_waddr = 8'd2; im_wdata = 32'h99;
    step();
    im_we = 1'b0;
    n_chk++;
    if (ifid_ins !== 32'h33 || ifid_pc !== 32'h8)
      $display("FAIL coll_old got ins=%h ipc=%h exp ins=33 ipc=8", ifid_ins, ifid_pc);
    else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h8;
    step();
    redirect = 1'b0;
    step();
    n_chk++;
    if (ifid_ins !== 32'h99) $display("FAIL coll_new got %h exp 99", ifid_ins);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    redirect = 1'b1; redirect_pc = 32'h402;
    step();
    redirect = 1'b0;
    step();
    n_chk++;
    if (fetch_cnt !== 32'd7 || range_err !== 1'b1 || align_err !== 1'b1)
      $display("FAIL pre_async got cnt=%0d r=%b a=%b exp cnt=7 r=1 a=1",
               fetch_cnt, range_err, align_err);
    else n_pass++;
    stall = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    n_chk++;
    if (pc !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0 ||
        ifid_ins !== NOP || ifid_valid !== 1'b0 || range_err !== 1'b0 ||
        align_err !== 1'b0 || fetch_cnt !== 32'h0)
      $display("FAIL async got pc=%h ipc=%h p4=%h ins=%h v=%b r=%b a=%b cnt=%0d exp reset values",
               pc, ifid_pc, ifid_pc4, ifid_ins, ifid_valid, range_err,
               align_err, fetch_cnt);
    else n_pass++;
    RST = 1'b0;
    stall = 1'b0;
    step();
    n_chk++;
    if (ifid_ins !== 32'h11 || pc !== 32'h4 || fetch_cnt !== 32'd1)
      $display("FAIL post_async got ins=%h pc=%h cnt=%0d exp ins=11 pc=4 cnt=1",
               ifid_ins, pc, fetch_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_out_of_range();
    test_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
